// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared FSM states, error codes and marker bytes
// for the JPEG capture-path frame sequencer.
package jpeg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_ENCODE,
    ST_DRAIN,
    ST_ERROR
  } frame_state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_SOI  = 2'b01,
    ERR_EOI  = 2'b10,
    ERR_OVF  = 2'b11
  } err_code_t;

  localparam logic [7:0] JPEG_MARK_FF = 8'hFF;
  localparam logic [7:0] JPEG_SOI_LO  = 8'hD8;
  localparam logic [7:0] JPEG_EOI_LO  = 8'hD9;

endpackage

// File: rtl/jpeg_marker_chk.sv
// jpeg_marker_chk: SOI/EOI marker checks on the encoder byte
// stream; keeps the previous accepted byte for the EOI pair.
module jpeg_marker_chk
  import jpeg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_vld,
  input  logic        byte_last,
  input  logic [7:0]  byte_data,
  input  logic [23:0] byte_idx,
  output logic        soi_bad,
  output logic        eoi_bad
);

  logic [7:0] prev_q;
  logic [7:0] prev_d;

  always_comb begin
    prev_d = prev_q;
    if (byte_vld) prev_d = byte_data;
  end

  always_ff @(posedge clk) begin
    if (rst) prev_q <= '0;
    else     prev_q <= prev_d;
  end

  // Flags are only meaningful while byte_vld is high.
  always_comb begin
    soi_bad = 1'b0;
    if (byte_idx == 24'd0)
      soi_bad = (byte_data != JPEG_MARK_FF);
    else if (byte_idx == 24'd1)
      soi_bad = (byte_data != JPEG_SOI_LO);
    eoi_bad = byte_last &&
              !((prev_q == JPEG_MARK_FF) &&
                (byte_data == JPEG_EOI_LO) &&
                (byte_idx >= 24'd3));
  end

endmodule

// File: rtl/jpeg_frame_ctrl.sv
// jpeg_frame_ctrl: frame sequencer (start, byte monitor, UART drain).
// Optional watchdog enabled with `define JPEG_FRAME_CTRL_WDT_EN.
module jpeg_frame_ctrl
  import jpeg_pkg::*;
#(
  parameter logic [23:0] MAX_BYTES  = 24'd1_048_575,
  parameter logic [31:0] WDT_CYCLES = 32'd100_000_000
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        start_req,
  output logic        enc_start,
  input  logic        byte_vld,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  input  logic        uart_busy,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [23:0] frame_len
);

  frame_state_t state_q, state_d;
  err_code_t    code_q, code_d;
  logic [23:0]  cnt_q, cnt_d;
  logic         start_prev_q;
  logic         enc_start_q, enc_start_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         start_edge;
  logic         acc;
  logic         soi_bad;
  logic         eoi_bad;
  logic         wdt_trip;

  assign start_edge = start_req & ~start_prev_q;
  assign acc = byte_vld && (state_q == ST_ENCODE);

  jpeg_marker_chk u_chk (
    .clk       (sys_clk),
    .rst       (rst),
    .byte_vld  (acc),
    .byte_last (byte_last),
    .byte_data (byte_data),
    .byte_idx  (cnt_q),
    .soi_bad   (soi_bad),
    .eoi_bad   (eoi_bad)
  );

`ifdef JPEG_FRAME_CTRL_WDT_EN
  logic [31:0] wdt_q, wdt_d;

  always_comb begin
    wdt_d = wdt_q;
    if (state_q == ST_ARM)
      wdt_d = '0;
    else if (state_q == ST_ENCODE ||
             state_q == ST_DRAIN)
      wdt_d = wdt_q + 32'd1;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) wdt_q <= '0;
    else     wdt_q <= wdt_d;
  end

  assign wdt_trip = (wdt_q >= WDT_CYCLES - 32'd1);
`else
  logic wdt_unused;
  assign wdt_unused = ^WDT_CYCLES;
  assign wdt_trip = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (start_edge) begin
          state_d = ST_ARM;
          code_d  = ERR_NONE;
          cnt_d   = '0;
        end
      end
      ST_ARM: state_d = ST_ENCODE;
      ST_ENCODE: begin
        if (acc) begin
          cnt_d = cnt_q + 24'd1;
          if (soi_bad) begin
            state_d = ST_ERROR;
            code_d  = ERR_SOI;
          end else if (cnt_q >= MAX_BYTES) begin
            state_d = ST_ERROR;
            code_d  = ERR_OVF;
          end else if (eoi_bad) begin
            state_d = ST_ERROR;
            code_d  = ERR_EOI;
          end else if (byte_last) begin
            state_d = ST_DRAIN;
          end
        end else if (wdt_trip) begin
          state_d = ST_ERROR;
          code_d  = ERR_OVF;
        end
      end
      ST_DRAIN: begin
        if (!uart_busy) begin
          state_d = ST_IDLE;
        end else if (wdt_trip) begin
          state_d = ST_ERROR;
          code_d  = ERR_OVF;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with it.
  always_comb begin
    enc_start_d = (state_d == ST_ARM);
    busy_d      = (state_d == ST_ARM) ||
                  (state_d == ST_ENCODE) ||
                  (state_d == ST_DRAIN);
    done_d      = (state_q == ST_DRAIN) &&
                  (state_d == ST_IDLE);
    err_d       = (state_d == ST_ERROR);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      code_q       <= ERR_NONE;
      cnt_q        <= '0;
      start_prev_q <= 1'b1;
      enc_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      cnt_q        <= cnt_d;
      start_prev_q <= start_req;
      enc_start_q  <= enc_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign enc_start = enc_start_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = code_q;
  assign frame_len = cnt_q;

endmodule
